counter_hex_display: RTL and testbench
======================================

COUNTER_HEX_DISPLAY -- requirements
Module: counter_hex_display

Interface
REQ-001 SHALL have parameter WIDTH, default 6, counter width in bits (1..24).
REQ-002 SHALL have parameter DIGITS, default 6, number of seven-segment digits driven (1..8).
REQ-003 SHALL have parameter PRESCALE, default 50_000_000, clk cycles per count tick (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable, sampled on tick cycles.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port wrap_en  input  1  1 = wrap at boundary, 0 = saturate.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value captured on load.
REQ-011 SHALL have port disp_hex  input  1  1 = hex display, 0 = binary display.
REQ-012 SHALL have port q  output  WIDTH  current count.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port seg  output  7*DIGITS  digit i on seg[7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick = prescaler at PRESCALE-1 (PRESCALE=1: tick every cycle).
REQ-016 Priority per cycle SHALL be: load > tick&en > hold.
REQ-017 load=1 SHALL set q <= load_val and prescaler <= 0 on the next edge, independent of tick/en; tc <= 0.
REQ-018 On tick&en&!load with up=1: q<max -> q+1; q=max -> 0 if wrap_en else hold max.
REQ-019 On tick&en&!load with up=0: q>0 -> q-1; q=0 -> max if wrap_en else hold 0.
REQ-020 max SHALL be 2^WIDTH-1; all arithmetic modulo 2^WIDTH, no overflow beyond WIDTH bits.
REQ-021 tc SHALL be 1 for exactly one cycle following every tick&en&!load where q was at the boundary for the current direction (max if up, 0 if down), in both wrap and saturate modes; else 0.
REQ-022 Without tick, or with en=0, q and tc SHALL hold/clear respectively; prescaler SHALL run regardless of en.
REQ-023 seg SHALL be registered, reflecting q and disp_hex of the previous cycle (latency 1 clk).
REQ-024 Binary mode: digit i < WIDTH SHALL show q[i] as "0"=7'b1000000 or "1"=7'b1111001; digits i >= WIDTH blank 7'b1111111.
REQ-025 Hex mode: digit i < ceil(WIDTH/4) SHALL show nibble q[4i+3:4i] (upper bits zero-padded) using 0-F glyphs 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit); other digits blank 7'b1111111.
REQ-026 Changing up, wrap_en or disp_hex mid-count SHALL take effect on the next tick (up/wrap_en) or next edge (disp_hex) with no glitch state.

Reset
REQ-027 reset=1 SHALL immediately, without clk, force q=0, prescaler=0, tc=0, seg=all ones (all blank).
REQ-028 Reset asserted mid-count or during load SHALL dominate; first count tick after release SHALL occur PRESCALE cycles after the first post-release edge.
REQ-029 After release, seg SHALL show the q=0 pattern from the first edge onward.

Verification (WIDTH=6, DIGITS=6, PRESCALE=4)
REQ-030 Reset release, en=1, up=1, disp_hex=0 -> q increments every 4 clk: 0,1,2,3; seg[6:0]=7'b1111001 one cycle after q=1.
REQ-031 load_val=63, up=1, wrap_en=1, en=1 -> next tick q=0, tc=1 for one cycle; wrap_en=0 -> q stays 63, tc pulses each tick.
REQ-032 load_val=0, up=0, wrap_en=1 -> next tick q=63, tc pulse; wrap_en=0 -> q holds 0.
REQ-033 disp_hex=1, load_val=6'h2A -> seg[6:0]=7'h08 ("A"), seg[13:7]=7'h24 ("2"), digits 2..5 = 7'h7F.
REQ-034 load and tick&en same cycle -> q=load_val, no increment, tc=0, prescaler restarts at 0.
REQ-035 reset pulse between edges mid-count (q=37) -> q=0, tc=0, seg=all ones immediately, before next clk edge.

Source files
------------

// File: rtl/counter_hex_display.sv
// Prescaled up/down counter with wrap/saturate modes, terminal-count pulse and
// a registered seven-segment readout (binary bits or hex nibbles, active-low).
module counter_hex_display #(
  parameter int WIDTH    = 6,
  parameter int DIGITS   = 6,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  disp_hex,
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              NHEX     = (WIDTH + 3) / 4;
  localparam logic [WIDTH-1:0] MAXV    = '1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       r_pre;
  logic [WIDTH-1:0]    r_q;
  logic                r_tc;
  logic [7*DIGITS-1:0] r_seg;

  logic                w_tick;
  logic                w_at_bound;
  logic [WIDTH-1:0]    w_q_next;
  logic [31:0]         w_qpad;
  logic [7*DIGITS-1:0] w_seg;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // With PRESCALE=1 r_pre is pinned at 0, so every cycle is a tick.
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_at_bound = up ? (r_q == MAXV) : (r_q == '0);
  assign w_qpad     = {{(32-WIDTH){1'b0}}, r_q};

  always_comb begin
    w_q_next = r_q;
    if (w_at_bound) begin
      if (wrap_en) w_q_next = up ? '0 : MAXV;
    end else begin
      w_q_next = up ? r_q + 1'b1 : r_q - 1'b1;
    end
  end

  // Zero-padded copy of q lets out-of-range digits index safely.
  always_comb begin
    w_seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_hex) begin
        if (i < NHEX) w_seg[7*i +: 7] = hex_glyph(w_qpad[4*i +: 4]);
      end else if (i < WIDTH) begin
        w_seg[7*i +: 7] = w_qpad[i] ? 7'h79 : 7'h40;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_seg <= '1;
    end else begin
      r_seg <= w_seg;
      r_tc  <= 1'b0;
      if (load) begin
        r_q   <= load_val;
        r_pre <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick && en) begin
          r_q  <= w_q_next;
          r_tc <= w_at_bound;
        end
      end
    end
  end

  assign q   = r_q;
  assign tc  = r_tc;
  assign seg = r_seg;

endmodule

// File: tb/tb_counter_hex_display.sv
// Directed bench for counter_hex_display (WIDTH=6, DIGITS=6, PRESCALE=4);
// expectations are queued as stimulus is applied and scored at negedges.
module tb_counter_hex_display;
  localparam int W = 6;
  localparam int D = 6;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           en, up, wrap_en, load, disp_hex;
  logic [W-1:0]   load_val;
  logic [W-1:0]   q;
  logic           tc;
  logic [7*D-1:0] seg;

  always #5 clk = ~clk;

  counter_hex_display #(.WIDTH(W), .DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .wrap_en(wrap_en),
    .load(load), .load_val(load_val), .disp_hex(disp_hex),
    .q(q), .tc(tc), .seg(seg)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [41:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] BLANK = '1;

  function automatic logic [41:0] exp_seg(input logic [5:0] v, input logic hex);
    logic [41:0] s;
    s = '1;
    if (hex) begin
      s[6:0]  = GL[v[3:0]];
      s[13:7] = GL[{2'b00, v[5:4]}];
    end else begin
      for (int i = 0; i < 6; i++) s[7*i +: 7] = v[i] ? 7'h79 : 7'h40;
    end
    return s;
  endfunction

  task automatic push(input string tag, input int kind, input logic [41:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic exp_qt(input string tag, input logic [5:0] eq, input logic et);
    push({tag, ".q"}, 0, 42'(eq));
    push({tag, ".tc"}, 1, 42'(et));
  endtask

  task automatic exp_sg(input string tag, input logic [41:0] es);
    push({tag, ".seg"}, 2, es);
  endtask

  task automatic score();
    exp_t        e;
    logic [41:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = 42'(q);
        1:       obs = 42'(tc);
        default: obs = seg;
      endcase
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [5:0] v);
    load_val = v;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; wrap_en = 1'b0;
    load = 1'b0; load_val = '0; disp_hex = 1'b0;

    @(negedge clk);
    exp_qt("rst", 6'd0, 1'b0); exp_sg("rst", BLANK); score();

    reset = 1'b0; en = 1'b1; up = 1'b1; wrap_en = 1'b1;
    step(1); exp_qt("rel", 6'd0, 1'b0); exp_sg("rel", exp_seg(6'd0, 1'b0)); score();
    step(3); exp_qt("cnt1", 6'd1, 1'b0); score();
    step(1); exp_sg("cnt1", exp_seg(6'd1, 1'b0)); score();
    step(3); exp_qt("cnt2", 6'd2, 1'b0); score();
    step(4); exp_qt("cnt3", 6'd3, 1'b0); score();

    do_load(6'd63); exp_qt("ld63", 6'd63, 1'b0); score();
    step(4); exp_qt("upwrap", 6'd0, 1'b1); score();
    step(1); exp_qt("upwrap_tcclr", 6'd0, 1'b0); score();

    wrap_en = 1'b0;
    do_load(6'd63); exp_qt("ld63s", 6'd63, 1'b0); score();
    step(4); exp_qt("upsat1", 6'd63, 1'b1); score();
    step(1); exp_qt("upsat_tcclr", 6'd63, 1'b0); score();
    step(3); exp_qt("upsat2", 6'd63, 1'b1); score();

    up = 1'b0; wrap_en = 1'b1;
    do_load(6'd0); exp_qt("ld0", 6'd0, 1'b0); score();
    step(4); exp_qt("dnwrap", 6'd63, 1'b1); score();
    step(1); exp_qt("dnwrap_tcclr", 6'd63, 1'b0); score();

    wrap_en = 1'b0;
    do_load(6'd0);
    step(4); exp_qt("dnsat1", 6'd0, 1'b1); score();
    step(4); exp_qt("dnsat2", 6'd0, 1'b1); score();

    en = 1'b0; up = 1'b1; wrap_en = 1'b1;
    step(4); exp_qt("hold_en0", 6'd0, 1'b0); score();

    disp_hex = 1'b1;
    do_load(6'h2A); exp_qt("ld2a", 6'h2A, 1'b0); score();
    step(1); exp_sg("hex2a", {{4{7'h7F}}, 7'h24, 7'h08}); score();
    disp_hex = 1'b0;
    step(1); exp_sg("bin2a", exp_seg(6'h2A, 1'b0)); score();

    en = 1'b1;
    do_load(6'd63);
    step(3); exp_qt("pre_tick", 6'd63, 1'b0); score();
    load_val = 6'd20; load = 1'b1;
    step(1); load = 1'b0;
    exp_qt("ld_over_tick", 6'd20, 1'b0); score();
    step(3); exp_qt("ld_restart", 6'd20, 1'b0); score();
    step(1); exp_qt("ld_next", 6'd21, 1'b0); score();

    do_load(6'd37);
    step(2); exp_qt("pre_rst", 6'd37, 1'b0); score();
    #2 reset = 1'b1;
    #1 exp_qt("async_rst", 6'd0, 1'b0); exp_sg("async_rst", BLANK); score();
    @(negedge clk);
    reset = 1'b0;
    step(1); exp_qt("rel2", 6'd0, 1'b0); exp_sg("rel2", exp_seg(6'd0, 1'b0)); score();
    step(3); exp_qt("rel2_tick", 6'd1, 1'b0); score();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
